// File: rtl/riscv_scoreboard.sv
// Register-hazard scoreboard between ID and EX: per-register pending counters, an in-flight cap and a sticky error flag.
// Optional macro SB_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue in that same cycle.
module riscv_scoreboard #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_rdy,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_vld,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_vld,
  input  logic [4:0] id_rsd,
  output logic       issue_ack,
  output logic       stall,
  input  logic       wb_vld,
  input  logic [4:0] wb_rsd,
  input  logic       flush,
  output logic [1:0] inflight,
  output logic       err
);

  localparam logic [1:0] MaxInfl = 2'(MAX_INFLIGHT);

  // Entry 0 exists only so x0 lookups read a constant zero; it is never written.
  logic [1:0] pend_q [32];
  logic [1:0] pend_d [32];
  logic [1:0] inflight_q, inflight_d;
  logic       err_q, err_d;

  logic [1:0] rs1_cnt, rs2_cnt, wb_cnt;
  logic       wb_nz, retire, wb_bad;
  logic       rs1_byp, rs2_byp, rs1_haz, rs2_haz, hazard;
  logic       full_blk, issue_wb, same_reg;

  assign rs1_cnt = pend_q[id_rs1];
  assign rs2_cnt = pend_q[id_rs2];
  assign wb_cnt  = pend_q[wb_rsd];

  assign wb_nz  = (wb_rsd != 5'd0);
  assign retire = wb_vld && wb_nz && (wb_cnt != 2'd0) && !flush;
  assign wb_bad = wb_vld && wb_nz && (wb_cnt == 2'd0) && !flush;

`ifdef SB_WB_BYPASS_EN
  assign rs1_byp = retire && (wb_rsd == id_rs1) && (rs1_cnt == 2'd1);
  assign rs2_byp = retire && (wb_rsd == id_rs2) && (rs2_cnt == 2'd1);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_haz = id_rs1_vld && (id_rs1 != 5'd0) && (rs1_cnt != 2'd0) && !rs1_byp;
  assign rs2_haz = id_rs2_vld && (id_rs2 != 5'd0) && (rs2_cnt != 2'd0) && !rs2_byp;
  assign hazard  = rs1_haz || rs2_haz;

  // A retire in the same cycle frees a slot, so a full window does not block.
  assign full_blk  = (id_rsd != 5'd0) && (inflight_q == MaxInfl) && !retire;
  assign issue_ack = rstn && id_rdy && !hazard && !flush && !full_blk;
  assign stall     = rstn && id_rdy && !issue_ack;

  assign issue_wb = issue_ack && (id_rsd != 5'd0);
  assign same_reg = issue_wb && retire && (wb_rsd == id_rsd);

  always_comb begin
    pend_d     = pend_q;
    inflight_d = inflight_q;
    err_d      = err_q | wb_bad;
    if (flush) begin
      for (int i = 0; i < 32; i++) pend_d[i] = 2'd0;
      inflight_d = 2'd0;
    end else begin
      if (issue_wb && !same_reg) pend_d[id_rsd] = pend_q[id_rsd] + 2'd1;
      if (retire && !same_reg)   pend_d[wb_rsd] = pend_q[wb_rsd] - 2'd1;
      case ({issue_wb, retire})
        2'b10:   inflight_d = inflight_q + 2'd1;
        2'b01:   inflight_d = inflight_q - 2'd1;
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) pend_q[i] <= 2'd0;
      inflight_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Scoreboard bench for riscv_scoreboard: a behavioural model pushes expected outputs, DUT samples pop and compare.
// Expectations follow SB_WB_BYPASS_EN when the bench is built with it.
module tb_riscv_scoreboard;

  localparam int MAXI = 3;
`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_rdy, id_rs1_vld, id_rs2_vld, wb_vld, flush;
  logic [4:0] id_rs1, id_rs2, id_rsd, wb_rsd;
  logic       issue_ack, stall, err;
  logic [1:0] inflight;

  riscv_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rstn(rstn),
    .id_rdy(id_rdy), .id_rs1(id_rs1), .id_rs1_vld(id_rs1_vld),
    .id_rs2(id_rs2), .id_rs2_vld(id_rs2_vld), .id_rsd(id_rsd),
    .issue_ack(issue_ack), .stall(stall),
    .wb_vld(wb_vld), .wb_rsd(wb_rsd), .flush(flush),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  string tag_q[$];
  int    exp_q[$];

  int pend_m[32];
  int infl_m;
  bit err_m;
  bit last_iss, last_stl;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
    else chk(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
    infl_m = 0;
    err_m  = 1'b0;
  endtask

  // One clock of stimulus: combinational outputs checked mid-cycle, registered outputs after the edge.
  task automatic cyc(input bit rdy, input int rs1, input bit v1, input int rs2, input bit v2,
                     input int rsd, input bit wbv, input int wbr, input bit fl);
    bit ret, h1, h2, iss, stl;
    @(negedge clk);
    id_rdy = rdy; id_rs1 = 5'(rs1); id_rs1_vld = v1; id_rs2 = 5'(rs2); id_rs2_vld = v2;
    id_rsd = 5'(rsd); wb_vld = wbv; wb_rsd = 5'(wbr); flush = fl;
    ret = wbv && wbr != 0 && pend_m[wbr] != 0 && !fl;
    h1  = v1 && rs1 != 0 && pend_m[rs1] != 0 && !(BYP && ret && wbr == rs1 && pend_m[rs1] == 1);
    h2  = v2 && rs2 != 0 && pend_m[rs2] != 0 && !(BYP && ret && wbr == rs2 && pend_m[rs2] == 1);
    iss = rdy && !h1 && !h2 && !fl && !(rsd != 0 && infl_m == MAXI && !ret);
    stl = rdy && !iss;
    sb_push("issue_ack", int'(iss));
    sb_push("stall", int'(stl));
    #1;
    last_iss = issue_ack;
    last_stl = stall;
    sb_pop(32'(issue_ack));
    sb_pop(32'(stall));
    if (fl) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
      infl_m = 0;
    end else begin
      if (wbv && wbr != 0 && pend_m[wbr] == 0) err_m = 1'b1;
      if (iss && rsd != 0) begin pend_m[rsd]++; infl_m++; end
      if (ret) begin pend_m[wbr]--; infl_m--; end
    end
    sb_push("inflight", infl_m);
    sb_push("err", int'(err_m));
    @(posedge clk);
    #1;
    sb_pop(32'(inflight));
    sb_pop(32'(err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; id_rdy = 1'b1; id_rsd = 5'd1;
    #1;
    chk("rst_issue_ack", 32'(issue_ack), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err", 32'(err), 0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1; id_rdy = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    id_rdy = 1'b1; id_rs1 = '0; id_rs1_vld = 1'b0; id_rs2 = '0; id_rs2_vld = 1'b0;
    id_rsd = 5'd3; wb_vld = 1'b0; wb_rsd = '0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("por_issue_ack", 32'(issue_ack), 0);
    chk("por_stall", 32'(stall), 0);
    chk("por_inflight", 32'(inflight), 0);
    chk("por_err", 32'(err), 0);
    @(negedge clk);
    rstn = 1'b1; id_rdy = 1'b0;

    // RAW hazard on x5 resolved by its writeback
    cyc(1, 0, 0, 0, 0, 5, 0, 0, 0);
    chk("raw_issue5", 32'(last_iss), 1);
    chk("raw_infl1", 32'(inflight), 1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("raw_stall_a", 32'(last_stl), 1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("raw_stall_b", 32'(last_stl), 1);
    cyc(1, 5, 1, 0, 0, 0, 1, 5, 0);
    chk("wb_cycle_issue", 32'(last_iss), int'(BYP));
    chk("raw_infl0", 32'(inflight), 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("after_wb_issue", 32'(last_iss), 1);

    // in-flight cap
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 3, 0, 0, 0);
    chk("cap_infl3", 32'(inflight), 3);
    cyc(1, 0, 0, 0, 0, 4, 0, 0, 0);
    chk("cap_stall_rsd4", 32'(last_stl), 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cap_issue_rsd0", 32'(last_iss), 1);
    chk("cap_rsd0_infl", 32'(inflight), 3);
    cyc(1, 0, 0, 0, 0, 4, 1, 1, 0);
    chk("cap_issue_with_retire", 32'(last_iss), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 0);
    chk("cap_drained", 32'(inflight), 0);

    // issue and retire of the same register in one cycle
    cyc(1, 0, 0, 0, 0, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 7, 0);
    chk("same_issue", 32'(last_iss), 1);
    chk("same_infl", 32'(inflight), 1);
    cyc(1, 7, 1, 0, 0, 0, 0, 0, 0);
    chk("same_pend_kept", 32'(last_stl), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0);
    cyc(1, 0, 0, 7, 1, 0, 0, 0, 0);
    chk("same_rs2_free", 32'(last_iss), 1);

    // spurious writebacks, x0 sources
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("wb_x0_no_err", 32'(err), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0);
    chk("wb_unpend_err", 32'(err), 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("err_survives_flush", 32'(err), 1);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("x0_src_no_stall", 32'(last_iss), 1);

    // flush with two writebacks in flight
    cyc(1, 0, 0, 0, 0, 10, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 11, 0, 0, 0);
    chk("flush_pre_infl", 32'(inflight), 2);
    cyc(1, 0, 0, 0, 0, 12, 1, 10, 1);
    chk("flush_no_issue", 32'(last_iss), 0);
    chk("flush_infl0", 32'(inflight), 0);
    cyc(1, 10, 1, 11, 1, 0, 0, 0, 0);
    chk("flush_srcs_free", 32'(last_iss), 1);

    // reset in the middle of activity
    cyc(1, 0, 0, 0, 0, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4, 0, 0, 0);
    do_reset();
    cyc(1, 3, 1, 4, 1, 0, 0, 0, 0);
    chk("midrst_srcs_free", 32'(last_iss), 1);

    // random traffic over a small register window
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1) != 0,
          $urandom_range(0, 4), $urandom_range(0, 1) != 0, $urandom_range(0, 4),
          $urandom_range(0, 1) != 0, $urandom_range(0, 4), $urandom_range(0, 15) == 0);
    end

    if (exp_q.size() != 0) chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
